counter_display_ctrl: RTL and testbench
=======================================

Name: counter_display_ctrl

Overview:
- Run/pause/clear controller for the two-digit seven-segment counter datapath.
- Sequences a bounded up/down count at a programmable step rate.
- Drives a 14-bit active-low segment bus {tens, ones}; segment order abcdefg, a at MSB.
- Sits between board push-button sync logic and the display pins.

Parameters:
- TICK_DIV, 1, clock cycles per count step (≥1).
- MAX_COUNT, 99, terminal count value (1..99; elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; begin or resume counting.
- pause  input  1  level; freeze count, keep prescaler.
- clear  input  1  level; return to 0 and idle.
- up_dn  input  1  1 = count up, 0 = count down; sampled at each step.
- busy  output  1  high in RUN.
- wrap  output  1  one-cycle pulse on a wrap-around step.
- count  output  7  binary count value.
- result  output  14  {tens seg, ones seg}, active-low.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - state IDLE, count 0, prescaler 0, busy 0, wrap 0.
  - result 14'b11111110000001 (tens blank, ones "0").
- FSM states: IDLE, RUN, PAUSED. Command priority: clear > pause > start.
- IDLE:
  - start → RUN with prescaler 0.
  - pause alone is ignored.
- RUN:
  - prescaler increments each cycle; at TICK_DIV-1 it returns to 0 and count steps.
  - pause → PAUSED, no step that cycle even if the tick coincides.
- PAUSED:
  - start → RUN; prescaler resumes from its retained value.
- clear in any state → IDLE next edge; count 0, prescaler 0, no wrap pulse.
- Step rules:
  - up: count+1; at MAX_COUNT → 0 with wrap=1 for that cycle.
  - down: count-1; at 0 → MAX_COUNT with wrap=1.
- Latency:
  - count is registered.
  - result is combinational from count, so it is valid in the same cycle as count.
  - First step occurs TICK_DIV cycles after the RUN entry edge.
- Display encoding:
  - tens = count/10, ones = count%10.
  - Tens digit blank (1111111) when count < 10.
  - Ones digit always shown.
  - Digit codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- up_dn toggled mid-run takes effect at the next step only.
- rst asserted mid-operation forces reset values immediately, independent of clk.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined:
  - At a terminal step (up at MAX_COUNT, down at 0) count holds, FSM → IDLE, wrap pulses once as a "done" indication.
  - A later start restarts from the held value.
- Undefined: wrap-around behaviour as above; FSM stays in RUN.

Decomposition:
- Package counter_display_pkg:
  - state enum type (IDLE/RUN/PAUSED).
  - SEG_BLANK constant.
  - SEG_DIGIT[0:9] lookup constant array.
  - segment bus width constant (7).
- Sub-module seg7_decoder:
  - input: 4-bit digit plus blank flag.
  - output: 7-bit active-low segments.
  - instantiated twice (tens, ones).

Test Plan:
- Reset then release with TICK_DIV=1, start=1, up_dn=1 → result sequence per edge 11111110000001, 11111111001111, 11111110010010, 11111110000110; busy=1 after the first edge.
- TICK_DIV=1, MAX_COUNT=12, count reaches 9 then next step → result 10011110000001 (tens "1", ones "0"); at 12 the next step gives count 0 with wrap=1 for exactly one cycle.
- TICK_DIV=3, start → count stays 0 for 3 cycles, then 1. Assert pause on a tick cycle → count unchanged, state PAUSED. Release pause, start → next step after the remaining prescaler cycles.
- up_dn=0 from 0 with MAX_COUNT=99 → count 99, result 00001000000100, wrap=1.
- clear and start asserted together during RUN at count 5 → count 0, IDLE, busy 0, no wrap. Async rst pulse between edges → outputs return to reset values immediately.
- With COUNTER_SATURATE_EN, MAX_COUNT=3 → counts 0..3, then state IDLE, count holds 3, wrap pulses once, busy 0.

Source files
------------

// File: rtl/counter_display_pkg.sv
// Shared types and constants for the two-digit seven-segment counter controller.
// Segment codes are active-low, ordered abcdefg with segment a at the MSB.
package counter_display_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    // Width of one digit's segment bus
    localparam int SEG_W = 7;

    // All segments off (active-low)
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Active-low segment patterns for decimal digits 0..9
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    // Split a binary value 0..99 into {tens, ones} BCD nibbles.
    // Comparison ladder instead of a divider: the range is tiny and fixed.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
        logic [3:0] tens;
        tens = 4'd0;
        for (int i = 1; i < 10; i++) begin
            tens = (value >= 7'(i * 10)) ? 4'(i) : tens;
        end
        return {tens, 4'(value - (7'(tens) * 7'd10))};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit seven-segment decoder, active-low outputs (abcdefg, a at MSB).
// A blank request or a non-decimal digit turns every segment off.
module seg7_decoder
    import counter_display_pkg::*;
(
    input  logic [3:0]       digit_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);

    // Look up the segment pattern for the digit, or blank it
    always_comb begin
        seg_o = SEG_BLANK;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (digit_i <= 4'd9) begin
            seg_o = SEG_DIGIT[digit_i];
        end else begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/counter_display_ctrl.sv
// Run/pause/clear controller for a two-digit seven-segment counter.
// Counts 0..MAX_COUNT up or down, one step every TICK_DIV clock cycles while
// running, and drives a 14-bit active-low {tens, ones} segment bus.
// Build option COUNTER_SATURATE_EN: instead of wrapping, a terminal step holds
// the count, returns to IDLE and pulses wrap once as a completion flag.
module counter_display_ctrl
    import counter_display_pkg::*;
#(
    parameter int TICK_DIV  = 1,
    parameter int MAX_COUNT = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic        up_dn,
    output logic        busy,
    output logic        wrap,
    output logic [6:0]  count,
    output logic [13:0] result
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [6:0]         MAX_VAL    = 7'(MAX_COUNT);

    generate
        if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max_count
            $error("counter_display_ctrl: MAX_COUNT must be within 1..99");
        end
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("counter_display_ctrl: TICK_DIV must be at least 1");
        end
    endgenerate

    state_e             state_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic [6:0]         count_q;
    logic [6:0]         count_step_d;
    logic               busy_q;
    logic               wrap_q;
    logic               tick_s;
    logic               terminal_s;
    logic [7:0]         bcd_s;
    logic               tens_blank_s;
    logic [SEG_W-1:0]   tens_seg_s;
    logic [SEG_W-1:0]   ones_seg_s;

    // Prescaler advance and the candidate next count for a step in the current direction
    always_comb begin
        tick_s       = (presc_q == PRESC_LAST);
        presc_d      = tick_s ? {PRESC_W{1'b0}} : (presc_q + PRESC_W'(1));
        count_step_d = count_q;
        terminal_s   = 1'b0;
        if (up_dn) begin
            if (count_q == MAX_VAL) begin
                count_step_d = 7'd0;
                terminal_s   = 1'b1;
            end else begin
                count_step_d = count_q + 7'd1;
                terminal_s   = 1'b0;
            end
        end else begin
            if (count_q == 7'd0) begin
                count_step_d = MAX_VAL;
                terminal_s   = 1'b1;
            end else begin
                count_step_d = count_q - 7'd1;
                terminal_s   = 1'b0;
            end
        end
    end

    // Control FSM with registered count, prescaler, busy and wrap; clear beats pause beats start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= {PRESC_W{1'b0}};
            count_q <= 7'd0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            presc_q <= {PRESC_W{1'b0}};
            count_q <= 7'd0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!pause && start) begin
                        state_q <= ST_RUN;
                        presc_q <= {PRESC_W{1'b0}};
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // A coinciding tick is dropped; prescaler is kept as-is
                        state_q <= ST_PAUSED;
                        busy_q  <= 1'b0;
                    end else begin
                        presc_q <= presc_d;
                        busy_q  <= 1'b1;
                        if (tick_s) begin
`ifdef COUNTER_SATURATE_EN
                            if (terminal_s) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                wrap_q  <= 1'b1;
                            end else begin
                                count_q <= count_step_d;
                            end
`else
                            count_q <= count_step_d;
                            wrap_q  <= terminal_s;
`endif
                        end else begin
                            count_q <= count_q;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause && start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    presc_q <= {PRESC_W{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Display digits follow the registered count combinationally
    always_comb begin
        bcd_s        = bin_to_bcd(count_q);
        tens_blank_s = (count_q < 7'd10);
    end

    seg7_decoder u_tens_dec (
        .digit_i (bcd_s[7:4]),
        .blank_i (tens_blank_s),
        .seg_o   (tens_seg_s)
    );

    seg7_decoder u_ones_dec (
        .digit_i (bcd_s[3:0]),
        .blank_i (1'b0),
        .seg_o   (ones_seg_s)
    );

    assign busy   = busy_q;
    assign wrap   = wrap_q;
    assign count  = count_q;
    assign result = {tens_seg_s, ones_seg_s};

endmodule

// File: tb/tb_counter_display_ctrl.sv
// Directed testbench for counter_display_ctrl. Four instances cover the
// parameter sets needed: A (TICK_DIV=1, MAX=99), B (TICK_DIV=1, MAX=12),
// C (TICK_DIV=3, MAX=99), D (TICK_DIV=1, MAX=3). Expectations for the
// COUNTER_SATURATE_EN build are selected with the same macro.
module tb_counter_display_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic a_start = 1'b0, a_pause = 1'b0, a_clear = 1'b0, a_up_dn = 1'b0;
    logic b_start = 1'b0, b_pause = 1'b0, b_clear = 1'b0, b_up_dn = 1'b0;
    logic c_start = 1'b0, c_pause = 1'b0, c_clear = 1'b0, c_up_dn = 1'b0;
    logic d_start = 1'b0, d_pause = 1'b0, d_clear = 1'b0, d_up_dn = 1'b0;
    logic a_busy, a_wrap, b_busy, b_wrap, c_busy, c_wrap, d_busy, d_wrap;
    logic [6:0]  a_count, b_count, c_count, d_count;
    logic [13:0] a_result, b_result, c_result, d_result;

    counter_display_ctrl #(.TICK_DIV(1), .MAX_COUNT(99)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .pause(a_pause), .clear(a_clear),
        .up_dn(a_up_dn), .busy(a_busy), .wrap(a_wrap), .count(a_count), .result(a_result));

    counter_display_ctrl #(.TICK_DIV(1), .MAX_COUNT(12)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .pause(b_pause), .clear(b_clear),
        .up_dn(b_up_dn), .busy(b_busy), .wrap(b_wrap), .count(b_count), .result(b_result));

    counter_display_ctrl #(.TICK_DIV(3), .MAX_COUNT(99)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .pause(c_pause), .clear(c_clear),
        .up_dn(c_up_dn), .busy(c_busy), .wrap(c_wrap), .count(c_count), .result(c_result));

    counter_display_ctrl #(.TICK_DIV(1), .MAX_COUNT(3)) dut_d (
        .clk(clk), .rst(rst), .start(d_start), .pause(d_pause), .clear(d_clear),
        .up_dn(d_up_dn), .busy(d_busy), .wrap(d_wrap), .count(d_count), .result(d_result));

    int n_cmp = 0;
    int n_bad = 0;

    // Count one comparison and report it if observed differs from expected
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus and checks
    initial begin
        // ---------------- reset values ----------------
        #12;
        chk("rst_count",  16'(a_count),  16'd0);
        chk("rst_result", 16'(a_result), 16'(14'b11111110000001));
        chk("rst_busy",   16'(a_busy),   16'd0);
        chk("rst_wrap",   16'(a_wrap),   16'd0);
        rst = 1'b0;

        // ---------------- A: start, count up at TICK_DIV=1 ----------------
        a_start = 1'b1;
        a_up_dn = 1'b1;
        step();
        chk("a_e1_result", 16'(a_result), 16'(14'b11111110000001));
        chk("a_e1_busy",   16'(a_busy),   16'd1);
        step();
        chk("a_e2_result", 16'(a_result), 16'(14'b11111111001111));
        step();
        chk("a_e3_result", 16'(a_result), 16'(14'b11111110010010));
        step();
        chk("a_e4_result", 16'(a_result), 16'(14'b11111110000110));
        step();
        step();
        chk("a_cnt5", 16'(a_count), 16'd5);

        // ---------------- A: clear wins over start ----------------
        a_clear = 1'b1;
        step();
        chk("a_clr_count",  16'(a_count),  16'd0);
        chk("a_clr_busy",   16'(a_busy),   16'd0);
        chk("a_clr_wrap",   16'(a_wrap),   16'd0);
        chk("a_clr_result", 16'(a_result), 16'(14'b11111110000001));
        step();
        chk("a_clr2_busy",  16'(a_busy),   16'd0);
        chk("a_clr2_count", 16'(a_count),  16'd0);

        // ---------------- A: count down through 0 ----------------
        a_clear = 1'b0;
        a_up_dn = 1'b0;
        step();
        chk("a_dn_start_busy",  16'(a_busy),  16'd1);
        chk("a_dn_start_count", 16'(a_count), 16'd0);
        step();
        chk("a_dn_wrap_count",  16'(a_count),  16'd99);
        chk("a_dn_wrap_result", 16'(a_result), 16'(14'b00001000000100));
        chk("a_dn_wrap_wrap",   16'(a_wrap),   16'd1);
        step();
        chk("a_dn_98_count", 16'(a_count), 16'd98);
        chk("a_dn_98_wrap",  16'(a_wrap),  16'd0);
        a_up_dn = 1'b1;
        step();
        chk("a_upturn_count", 16'(a_count), 16'd99);
        chk("a_upturn_wrap",  16'(a_wrap),  16'd0);
        step();
        chk("a_up_wrap_count", 16'(a_count), 16'd0);
        chk("a_up_wrap_wrap",  16'(a_wrap),  16'd1);
        step();
        chk("a_up_1_count", 16'(a_count), 16'd1);
        chk("a_up_1_wrap",  16'(a_wrap),  16'd0);

        // ---------------- A: async reset between edges ----------------
        #3;
        rst = 1'b1;
        #1;
        chk("a_arst_count",  16'(a_count),  16'd0);
        chk("a_arst_busy",   16'(a_busy),   16'd0);
        chk("a_arst_result", 16'(a_result), 16'(14'b11111110000001));
        #2;
        rst = 1'b0;
        a_start = 1'b0;
        step();
        chk("a_post_rst_busy", 16'(a_busy), 16'd0);

        // ---------------- B: MAX_COUNT=12, tens digit appears ----------------
        b_start = 1'b1;
        b_up_dn = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        chk("b_9_count",  16'(b_count),  16'd9);
        chk("b_9_result", 16'(b_result), 16'(14'b11111110000100));
        step();
        chk("b_10_result", 16'(b_result), 16'(14'b10011110000001));
        step();
        step();
        chk("b_12_result", 16'(b_result), 16'(14'b10011110010010));
        chk("b_12_wrap",   16'(b_wrap),   16'd0);
        step();
`ifdef COUNTER_SATURATE_EN
        chk("b_term_count", 16'(b_count), 16'd12);
        chk("b_term_wrap",  16'(b_wrap),  16'd1);
        chk("b_term_busy",  16'(b_busy),  16'd0);
        step();
        chk("b_restart_count", 16'(b_count), 16'd12);
        chk("b_restart_wrap",  16'(b_wrap),  16'd0);
`else
        chk("b_term_count", 16'(b_count), 16'd0);
        chk("b_term_wrap",  16'(b_wrap),  16'd1);
        chk("b_term_busy",  16'(b_busy),  16'd1);
        step();
        chk("b_after_count", 16'(b_count), 16'd1);
        chk("b_after_wrap",  16'(b_wrap),  16'd0);
`endif
        b_start = 1'b0;

        // ---------------- C: TICK_DIV=3 prescaler and pause ----------------
        c_pause = 1'b1;
        step();
        chk("c_idle_pause_busy", 16'(c_busy), 16'd0);
        c_pause = 1'b0;
        c_start = 1'b1;
        c_up_dn = 1'b1;
        step();
        chk("c_e0_busy",  16'(c_busy),  16'd1);
        chk("c_e0_count", 16'(c_count), 16'd0);
        step();
        chk("c_e1_count", 16'(c_count), 16'd0);
        step();
        chk("c_e2_count", 16'(c_count), 16'd0);
        step();
        chk("c_e3_count", 16'(c_count), 16'd1);
        step();
        step();
        c_pause = 1'b1;
        step();
        chk("c_pause_count", 16'(c_count), 16'd1);
        chk("c_pause_busy",  16'(c_busy),  16'd0);
        step();
        chk("c_pause2_count", 16'(c_count), 16'd1);
        chk("c_pause2_busy",  16'(c_busy),  16'd0);
        c_pause = 1'b0;
        step();
        chk("c_resume_count", 16'(c_count), 16'd1);
        chk("c_resume_busy",  16'(c_busy),  16'd1);
        step();
        chk("c_resume_step",   16'(c_count),  16'd2);
        chk("c_resume_result", 16'(c_result), 16'(14'b11111110010010));
        c_start = 1'b0;

        // ---------------- D: MAX_COUNT=3 terminal behaviour ----------------
        d_start = 1'b1;
        d_up_dn = 1'b1;
        step();
        step();
        step();
        step();
        chk("d_3_count",  16'(d_count),  16'd3);
        chk("d_3_result", 16'(d_result), 16'(14'b11111110000110));
        step();
        d_start = 1'b0;
`ifdef COUNTER_SATURATE_EN
        chk("d_term_count", 16'(d_count), 16'd3);
        chk("d_term_wrap",  16'(d_wrap),  16'd1);
        chk("d_term_busy",  16'(d_busy),  16'd0);
        step();
        chk("d_hold_count", 16'(d_count), 16'd3);
        chk("d_hold_wrap",  16'(d_wrap),  16'd0);
        chk("d_hold_busy",  16'(d_busy),  16'd0);
`else
        chk("d_term_count", 16'(d_count), 16'd0);
        chk("d_term_wrap",  16'(d_wrap),  16'd1);
        chk("d_term_busy",  16'(d_busy),  16'd1);
        step();
        chk("d_next_count", 16'(d_count), 16'd1);
        chk("d_next_wrap",  16'(d_wrap),  16'd0);
        chk("d_next_busy",  16'(d_busy),  16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
